// File: rtl/jpeg_huffman_encode_mc.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_huffman_encode_mc
// Purpose  : Multi-component JPEG 8x8 block Huffman symbol/amplitude encoder.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_huffman_encode_mc #(
   parameter int NUM_COMPONENTS = 3,
   parameter int COEFF_WIDTH    = 16,
   parameter int CID_WIDTH      = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [CID_WIDTH-1:0]          component_id,
   input  logic                          restart,
   output logic [5:0]                    fetch_addr,
   input  logic signed [COEFF_WIDTH-1:0] src_data_in,
   output logic [7:0]                    table_symbol,
   output logic                          table_is_ac,
   output logic                          table_sel,
   input  logic [15:0]                   table_code,
   input  logic [4:0]                    table_length,
   output logic                          output_wren,
   output logic [5:0]                    output_length,
   output logic [31:0]                   output_data,
   output logic                          busy
);
   localparam int c_VW    = COEFF_WIDTH + 1;
   localparam int c_NPRED = 1 << CID_WIDTH;
   localparam logic [CID_WIDTH:0] c_NUM_CMP = (CID_WIDTH + 1)'(NUM_COMPONENTS);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EVAL   = 3'd2,
      ST_LOOKUP = 3'd3,
      ST_EMIT   = 3'd4
   } state_t;

   state_t r_state, w_next;

   logic [5:0]                    r_idx;
   logic [5:0]                    r_run;
   logic [CID_WIDTH-1:0]          r_cid;
   logic signed [c_VW-1:0]        r_val;
   logic signed [COEFF_WIDTH-1:0] r_raw;
   logic signed [COEFF_WIDTH-1:0] r_pred [c_NPRED];

   logic                   w_accept, w_is_dc, w_zrl, w_eob, w_eval_zero;
   logic signed [c_VW-1:0] w_src_x, w_pred_x, w_eval_v, w_adj;
   logic [c_VW-1:0]        w_abs;
   logic [4:0]             w_cat, w_sym_cat;
   logic [7:0]             w_sym;
   logic [31:0]            w_mask, w_amp;

   assign w_accept    = start && ({1'b0, component_id} < c_NUM_CMP);
   assign w_src_x     = {src_data_in[COEFF_WIDTH-1], src_data_in};
   assign w_pred_x    = {r_pred[r_cid][COEFF_WIDTH-1], r_pred[r_cid]};
   assign w_eval_v    = (r_idx == 6'd0) ? (w_src_x - w_pred_x) : w_src_x;
   assign w_eval_zero = (w_eval_v == '0);

   // Symbol classification works from the value latched in EVAL
   assign w_is_dc   = (r_idx == 6'd0);
   assign w_eob     = !w_is_dc && (r_val == '0);
   assign w_zrl     = !w_is_dc && !w_eob && (r_run >= 6'd16);
   assign w_abs     = r_val[c_VW-1] ? -r_val : r_val;
   assign w_adj     = r_val[c_VW-1] ? (r_val - {{(c_VW-1){1'b0}}, 1'b1}) : r_val;
   assign w_sym_cat = (w_zrl || w_eob) ? 5'd0 : w_cat;
   assign w_mask    = (32'd1 << w_sym_cat) - 32'd1;
   assign w_amp     = {{(32-c_VW){1'b0}}, w_adj} & w_mask;
   assign busy      = (r_state != ST_IDLE);

   always_comb begin
      w_cat = 5'd0;
      for (int i = 0; i < c_VW; i++) begin
         if (w_abs[i]) w_cat = 5'(i + 1);
      end
   end

   always_comb begin
      if (w_is_dc)    w_sym = {3'b000, w_cat};
      else if (w_zrl) w_sym = 8'hF0;
      else if (w_eob) w_sym = 8'h00;
      else            w_sym = {r_run[3:0], w_cat[3:0]};
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      fetch_addr    = 6'd0;
      table_symbol  = 8'd0;
      table_is_ac   = 1'b0;
      table_sel     = 1'b0;
      output_wren   = 1'b0;
      output_length = 6'd0;
      output_data   = 32'd0;
      case (r_state)
         ST_IDLE:   if (w_accept) w_next = ST_FETCH;
         ST_FETCH: begin
            fetch_addr = r_idx;
            w_next     = ST_EVAL;
         end
         // Zero AC coefficients only bump the run; index 63 zero becomes EOB
         ST_EVAL: begin
            if ((r_idx != 6'd0) && w_eval_zero && (r_idx != 6'd63)) w_next = ST_FETCH;
            else                                                     w_next = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            table_symbol = w_sym;
            table_is_ac  = !w_is_dc;
            table_sel    = (r_cid != '0);
            w_next       = ST_EMIT;
         end
         ST_EMIT: begin
            output_wren   = 1'b1;
            output_data   = ({16'd0, table_code} << w_sym_cat) | w_amp;
            output_length = {1'b0, table_length} + {1'b0, w_sym_cat};
            if (w_zrl)                         w_next = ST_LOOKUP;
            else if (w_eob || r_idx == 6'd63)  w_next = ST_IDLE;
            else                               w_next = ST_FETCH;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_idx <= 6'd0;
         r_run <= 6'd0;
         r_cid <= '0;
         r_val <= '0;
         r_raw <= '0;
         for (int i = 0; i < c_NPRED; i++) r_pred[i] <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (restart) begin
                  for (int i = 0; i < c_NPRED; i++) r_pred[i] <= '0;
               end
               if (w_accept) begin
                  r_cid <= component_id;
                  r_idx <= 6'd0;
                  r_run <= 6'd0;
               end
            end
            ST_EVAL: begin
               r_val <= w_eval_v;
               r_raw <= src_data_in;
               if ((r_idx != 6'd0) && w_eval_zero) begin
                  r_run <= r_run + 6'd1;
                  if (r_idx != 6'd63) r_idx <= r_idx + 6'd1;
               end
            end
            ST_EMIT: begin
               if (w_zrl) begin
                  r_run <= r_run - 6'd16;
               end else begin
                  if (w_is_dc) r_pred[r_cid] <= r_raw;
                  if (!w_eob) begin
                     r_run <= 6'd0;
                     if (r_idx != 6'd63) r_idx <= r_idx + 6'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_jpeg_huffman_encode_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_huffman_encode_mc
// Purpose  : Scoreboard bench for jpeg_huffman_encode_mc with a stub table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_huffman_encode_mc;
   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              restart = 1'b0;
   logic [1:0]        component_id = 2'd0;
   logic [5:0]        fetch_addr;
   logic signed [15:0] src_data_in;
   logic [7:0]        table_symbol;
   logic              table_is_ac, table_sel;
   logic [15:0]       table_code;
   logic [4:0]        table_length;
   logic              output_wren;
   logic [5:0]        output_length;
   logic [31:0]       output_data;
   logic              busy;

   jpeg_huffman_encode_mc #(.NUM_COMPONENTS(3), .COEFF_WIDTH(16), .CID_WIDTH(2)) dut (
      .clock(clock), .reset(reset), .start(start), .component_id(component_id),
      .restart(restart), .fetch_addr(fetch_addr), .src_data_in(src_data_in),
      .table_symbol(table_symbol), .table_is_ac(table_is_ac), .table_sel(table_sel),
      .table_code(table_code), .table_length(table_length), .output_wren(output_wren),
      .output_length(output_length), .output_data(output_data), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct { int data; int len; } word_t;
   word_t sb[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_wren_cyc = 0;
   int pred[3];
   logic signed [15:0] mem [64];

   // Coefficient memory and stub Huffman table, both one cycle of latency
   always @(posedge clock) begin
      cyc          <= cyc + 1;
      src_data_in  <= mem[fetch_addr];
      table_code   <= {6'b0, table_is_ac, table_sel, table_symbol};
      table_length <= 5'd10;
   end

   always @(negedge clock) begin
      word_t w;
      if (!reset) begin
         if (output_wren) begin
            checks++;
            last_wren_cyc = cyc;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL extra_word: got data=%h len=%0d, expected no word", output_data, output_length);
            end else begin
               w = sb.pop_front();
               if (output_data !== 32'(w.data) || output_length !== 6'(w.len)) begin
                  errors++;
                  $display("FAIL word: got data=%h len=%0d, expected data=%h len=%0d",
                           output_data, output_length, w.data, w.len);
               end
            end
         end else begin
            checks++;
            if (output_data !== 32'd0 || output_length !== 6'd0) begin
               errors++;
               $display("FAIL idle_output: got data=%h len=%0d, expected 0/0", output_data, output_length);
            end
         end
      end
   end

   function automatic int catg(input int v);
      int a;
      int c;
      a = (v < 0) ? -v : v;
      c = 0;
      while (a > 0) begin
         c++;
         a = a >> 1;
      end
      return c;
   endfunction

   function automatic void push_sym(input int is_ac, input int sel, input int sym, input int v);
      word_t w;
      int c;
      int amp;
      c = catg(v);
      amp = ((v < 0) ? v - 1 : v) & ((1 << c) - 1);
      w.data = ((((is_ac << 9) | (sel << 8) | sym)) << c) | amp;
      w.len = 10 + c;
      sb.push_back(w);
   endfunction

   // Reference: DC difference, then run-length coded AC with deferred ZRLs
   task automatic expect_block(input int cid);
      int sel;
      int diff;
      int run;
      int v;
      sel = (cid != 0) ? 1 : 0;
      diff = int'(mem[0]) - pred[cid];
      push_sym(0, sel, catg(diff), diff);
      pred[cid] = int'(mem[0]);
      run = 0;
      for (int k = 1; k < 64; k++) begin
         v = int'(mem[k]);
         if (v == 0) begin
            run++;
         end else begin
            while (run >= 16) begin
               push_sym(1, sel, 8'hF0, 0);
               run -= 16;
            end
            push_sym(1, sel, (run << 4) | catg(v), v);
            run = 0;
         end
      end
      if (run > 0) push_sym(1, sel, 0, 0);
   endtask

   task automatic clear_mem();
      for (int k = 0; k < 64; k++) mem[k] = 16'sd0;
   endtask

   task automatic idle_restart();
      @(posedge clock); #1;
      restart = 1'b1;
      @(posedge clock); #1;
      restart = 1'b0;
      pred = '{default: 0};
   endtask

   task automatic run_block(input int cid, input bit with_restart, input bit poke);
      int t0;
      if (with_restart) pred = '{default: 0};
      expect_block(cid);
      @(posedge clock); #1;
      start = 1'b1;
      component_id = 2'(cid);
      restart = with_restart;
      @(posedge clock); #1;
      start = 1'b0;
      restart = 1'b0;
      t0 = cyc;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_rise: got busy=%b, expected 1", busy);
      end
      if (poke) begin
         repeat (5) @(posedge clock);
         #1;
         start = 1'b1;
         restart = 1'b1;
         component_id = 2'((cid + 1) % 3);
         @(posedge clock); #1;
         start = 1'b0;
         restart = 1'b0;
      end
      while (busy && (cyc - t0) < 300) begin
         @(posedge clock); #1;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL block_timeout: got busy=1 after %0d cycles, expected busy=0", cyc - t0);
      end else begin
         checks++;
         if ((cyc - t0) > 259) begin
            errors++;
            $display("FAIL latency: got %0d cycles start-to-idle, expected <= 260", cyc - t0 + 1);
         end
         checks++;
         if (cyc != last_wren_cyc + 1) begin
            errors++;
            $display("FAIL busy_fall: got fall at cycle %0d, expected %0d", cyc, last_wren_cyc + 1);
         end
         checks++;
         if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_words: got %0d words outstanding, expected 0", sb.size());
         end
         sb.delete();
      end
   endtask

   initial begin
      int dens;
      int v;
      clear_mem();
      pred = '{default: 0};
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || output_wren !== 1'b0 || fetch_addr !== 6'd0 ||
          output_data !== 32'd0 || output_length !== 6'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b wren=%b addr=%0d data=%h len=%0d, expected all 0",
                  busy, output_wren, fetch_addr, output_data, output_length);
      end
      reset = 1'b0;

      run_block(0, 1'b0, 1'b0);                          // all zero block
      mem[0] = 16'sd5;  run_block(0, 1'b0, 1'b0);
      mem[0] = 16'sd3;  run_block(0, 1'b0, 1'b0);
      clear_mem(); mem[20] = -16'sd1; run_block(0, 1'b1, 1'b0);
      clear_mem(); mem[1]  = 16'sd1;  run_block(0, 1'b1, 1'b0);
      clear_mem(); mem[63] = 16'sd1;  run_block(0, 1'b1, 1'b0);

      clear_mem();
      idle_restart();
      mem[0] = 16'sd10;
      run_block(0, 1'b0, 1'b0);
      run_block(1, 1'b0, 1'b0);
      run_block(0, 1'b0, 1'b1);                          // start/restart while busy ignored
      idle_restart();
      run_block(0, 1'b0, 1'b0);

      @(posedge clock); #1;
      start = 1'b1;
      component_id = 2'd3;
      @(posedge clock); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL bad_cid: got busy=%b, expected 0", busy);
      end

      for (int k = 0; k < 64; k++) mem[k] = 16'(k * 7 - 200);
      expect_block(2);
      @(posedge clock); #1;
      start = 1'b1;
      component_id = 2'd2;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (29) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      sb.delete();
      pred = '{default: 0};
      checks++;
      if (busy !== 1'b0 || output_wren !== 1'b0 || fetch_addr !== 6'd0) begin
         errors++;
         $display("FAIL reset_abort: got busy=%b wren=%b addr=%0d, expected 0/0/0",
                  busy, output_wren, fetch_addr);
      end
      clear_mem();
      mem[0] = 16'sd7;
      run_block(0, 1'b0, 1'b0);

      for (int k = 0; k < 64; k++) mem[k] = 16'(k + 1);  // densest block
      run_block(2, 1'b0, 1'b0);

      for (int b = 0; b < 20; b++) begin
         case ($urandom_range(0, 3))
            0: dens = 0;
            1: dens = 5;
            2: dens = 30;
            default: dens = 100;
         endcase
         for (int k = 0; k < 64; k++) begin
            v = int'($urandom_range(0, 2047)) - 1024;
            if (k == 0 || int'($urandom_range(0, 99)) < dens) mem[k] = 16'(v);
            else                                          mem[k] = 16'sd0;
         end
         run_block(int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
